// File: rtl/fp_add_issuer_if.sv
// Operand/result handshake bundle between an operand source/result consumer and fp_add_issuer.
// Ports: in_valid/in_ready/in_a/in_b carry operand pairs in; out_valid/out_ready/out_sum carry results out.
// master = source/consumer side, slave = issuer side.
interface fp_add_issuer_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/fp_add_issuer.sv
// Initiator for the FP adder's level-sensitive start/done protocol; one operation in flight at a time.
// Ports: i_clk/i_rst_n (async active-low), bus (slave: operand in, result out), o_op_a/o_op_b/o_start
// to the adder, i_done/i_sum_in from the adder, o_busy, o_timeout_err. Optional macro: FP_ISSUE_TIMEOUT_EN.
module fp_add_issuer #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fp_add_issuer_if.slave bus,
  output logic [W-1:0]  o_op_a,
  output logic [W-1:0]  o_op_b,
  output logic          o_start,
  input  logic          i_done,
  input  logic [W-1:0]  i_sum_in,
  output logic          o_busy,
  output logic          o_timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t       r_state;
  logic         r_start;
  logic         r_out_valid;
  logic         r_busy;
  logic [W-1:0] r_op_a;
  logic [W-1:0] r_op_b;
  logic [W-1:0] r_out_sum;

  logic w_in_ready;
  logic w_accept;
  logic w_wd_hit;

  // Acceptance is gated on done so a still-running adder is never re-started.
  assign w_in_ready = (r_state == S_IDLE) && i_done;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_out_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Operands stay put until the next acceptance; the adder loads them after start falls.
            r_op_a  <= bus.in_a;
            r_op_b  <= bus.in_b;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          // Hold start until the adder acknowledges by dropping done.
          if (!i_done) begin
            r_start <= 1'b0;
            r_state <= S_WAIT;
          end else if (w_wd_hit) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (i_done) begin
            r_out_sum   <= i_sum_in;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else if (w_wd_hit) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_start     <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] r_wd_cnt;
  logic          r_timeout_err;
  logic          w_stuck;

  // Stuck means the current wait state is not leaving on this edge.
  assign w_stuck  = ((r_state == S_ARM) && i_done) || ((r_state == S_WAIT) && !i_done);
  assign w_wd_hit = w_stuck && (r_wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wd_cnt <= '0;
      end else if ((r_state == S_ARM) || (r_state == S_WAIT)) begin
        r_wd_cnt <= r_wd_cnt + CW'(1);
      end
      if (w_wd_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_wd_hit      = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign o_op_a        = r_op_a;
  assign o_op_b        = r_op_b;
  assign o_start       = r_start;
  assign o_busy        = r_busy;

endmodule

// File: doc/fp_add_issuer.md
# fp_add_issuer

Initiator side of the floating-point adder's start/done handshake. Accepts operand pairs on a valid/ready input, holds them on the adder's operand bus, and sequences the adder's level-sensitive start/done protocol: raise start, wait for done to fall, drop start, wait for done to rise. It then captures the sum and presents it on a valid/ready output. It sits between the operand source (testbench or upstream datapath) and the FP adder top.

## Interface
- W, 32, operand and result width (IEEE-754 single)
- TIMEOUT, 64, watchdog limit in cycles; used only with the watchdog compiled in

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair available
- in_ready  out  1  issuer accepts a pair this cycle
- in_a, in_b  in  W  operands
- op_a, op_b  out  W  operands driven to the adder; registered
- start  out  1  adder start level; registered
- done  in  1  adder idle/complete level (1 = idle)
- sum_in  in  W  adder result bus
- out_valid  out  1  result held
- out_ready  in  1  consumer takes the result
- out_sum  out  W  captured result; registered
- busy  out  1  state is not IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- One clock and one reset. The reset is asynchronous and active-low.
- Reset values:
  - state IDLE
  - start=0, out_valid=0, timeout_err=0
  - op_a, op_b, out_sum = 0
  - watchdog counter = 0
- Reset mid-operation drops start immediately. It does not wait for the adder.
- States and transitions:
  - IDLE: in_ready = done. On in_valid&&in_ready, latch in_a/in_b into op_a/op_b and go to ARM.
  - ARM: start=1. When done==0 (adder has left its idle state), go to WAIT_DONE.
  - WAIT_DONE: start=0. When done==1, latch sum_in into out_sum and go to OUT.
  - OUT: out_valid=1. When out_ready==1, go to IDLE.
- in_ready=0 in every state except IDLE. There is no pipelining; at most one operation is in flight.
- op_a/op_b stay unchanged from acceptance until the next acceptance. The adder loads operands after start falls, so they must be stable then.
- out_sum and out_valid hold steady while out_valid=1 and out_ready=0.
- done==1 in ARM does not advance the state. start remains high until the adder acknowledges by dropping done.
- in_valid without done==1 in IDLE is stalled; no pair is accepted.

## Timing
- Operands are accepted at edge T. Then:
  - start=1 during cycle T+1.
  - The adder sees start and drops done during T+2.
  - The issuer enters WAIT_DONE at T+3, with start=0 from T+3.
- Result capture: on the first edge in WAIT_DONE where done==1, out_sum is updated. out_valid=1 from the next cycle.
- Output handshake: a transfer occurs on an edge where out_valid&&out_ready. The state is IDLE on the following cycle.
- Minimum spacing between acceptances = adder latency + 4 cycles.

## Configuration
- FP_ISSUE_TIMEOUT_EN defined:
  - A counter clears on entry to ARM and increments each cycle in ARM or WAIT_DONE.
  - When the counter reaches TIMEOUT-1 with no transition, the issuer sets timeout_err=1 (sticky until reset), forces start=0, and returns to IDLE.
  - The pending operation produces no output. IDLE still gates acceptance on done==1, so a hung adder is never re-started.
- FP_ISSUE_TIMEOUT_EN undefined: no counter is built, timeout_err is tied 0, and the issuer waits indefinitely.

## Test plan
- Single op. Bench behavioural adder with 6-cycle latency; in_a=32'h3F800000, in_b=32'h40000000. Required: start high for exactly 2 cycles, then out_sum=32'h40400000 with out_valid=1, held until out_ready.
- Backpressure. in_a=32'hC0A00000, in_b=32'h40A00000, out_ready held 0 for 10 cycles. Required: out_sum=32'h00000000 stable and out_valid=1 throughout; in_ready=0; exactly one transfer when out_ready rises.
- Back-to-back. Three pairs queued with in_valid held 1 (1+1, 2+2, 3+3). Required: outputs 32'h40000000, 32'h40800000, 32'h40C00000 in order; each acceptance only when the prior result has been taken and done==1.
- Adder busy at idle. Force done=0 while in_valid=1 for 5 cycles. Required: in_ready=0 and no acceptance; accepted on the first cycle done returns to 1.
- Async reset in WAIT_DONE. Drive rst=0 mid-cycle. Required: start, out_valid and busy go to 0 before the next clock edge; after release, the next accepted pair completes correctly.
- Watchdog (FP_ISSUE_TIMEOUT_EN, TIMEOUT=16). Adder model never drops done. Required: start=0 and timeout_err=1 after 16 cycles in ARM, state IDLE, no out_valid pulse; timeout_err stays 1 until reset.
